// File: rtl/rt_timer_sched_ctrl.sv
// Per-flow retransmit timer controller: prescaled tick sweeps all flow countdowns and
// issues a scheduler command (set rt_flag) for every armed timer that expires.
package tcp_misc_pkg;
  localparam int SCHED_SC_W = 2;
  localparam logic [SCHED_SC_W-1:0] SC_NOP = 2'b00;
  localparam logic [SCHED_SC_W-1:0] SC_SET = 2'b01;
  localparam logic [SCHED_SC_W-1:0] SC_CLR = 2'b10;
endpackage

module rt_timer_sched_ctrl
  import tcp_misc_pkg::*;
#(
  parameter int MAX_FLOW_CNT = 12,
  parameter int FLOW_CNT     = MAX_FLOW_CNT,
  parameter int TIMER_W      = 16,
  parameter int TICK_CYCLES  = 1024,
  localparam int FLOWID_W           = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1,
  localparam int SCHED_CMD_STRUCT_W = FLOWID_W + 3 * SCHED_SC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arm_val,
  input  logic [FLOWID_W-1:0]           arm_flowid,
  input  logic [TIMER_W-1:0]            arm_timeout,
  output logic                          arm_rdy,
  input  logic                          disarm_val,
  input  logic [FLOWID_W-1:0]           disarm_flowid,
  output logic                          disarm_rdy,
  output logic                          sched_update_val,
  output logic [SCHED_CMD_STRUCT_W-1:0] sched_update_cmd,
  input  logic                          sched_update_rdy,
  output logic                          tick_overrun,
  output logic [1:0]                    dbg_state,
  output logic [FLOWID_W-1:0]           dbg_idx
);

  // Handshakes: a transfer happens on a rising edge where both val and rdy are 1.
  // arm is always ready; disarm is ready only when no arm is presented that cycle.
  // sched_update_cmd is held stable from val rising until the transfer.

  localparam int PRE_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [FLOWID_W-1:0] IDX_LAST = FLOWID_W'(FLOW_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FLOWID_W-1:0]  idx_q, idx_d;
  logic [PRE_W-1:0]     pre_q;
  logic                 tick_pend_q;
  logic                 tick_overrun_q;
  logic                 armed_q  [FLOW_CNT];
  logic [TIMER_W-1:0]   remain_q [FLOW_CNT];

  logic                 pre_wrap;
  logic                 arm_hit, dis_acc, dis_hit, stall;
  logic [TIMER_W-1:0]   arm_to_eff;
  logic                 cur_armed;
  logic [TIMER_W-1:0]   cur_remain;
  logic                 tick_clr, eval, expire;

  assign pre_wrap   = (pre_q == PRE_LAST);
  assign arm_hit    = arm_val && ({{(32-FLOWID_W){1'b0}}, arm_flowid} < 32'(FLOW_CNT));
  assign dis_acc    = disarm_val && !arm_val;
  assign dis_hit    = dis_acc && ({{(32-FLOWID_W){1'b0}}, disarm_flowid} < 32'(FLOW_CNT));
  assign stall      = arm_val || dis_acc;
  assign arm_to_eff = (arm_timeout == '0) ? TIMER_W'(1) : arm_timeout;
  assign cur_armed  = armed_q[idx_q];
  assign cur_remain = remain_q[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick_clr = 1'b0;
    eval     = 1'b0;
    expire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_pend_q) begin
          tick_clr = 1'b1;
          idx_d    = '0;
          state_d  = S_SWEEP;
        end
      end
      S_SWEEP: begin
        // A table write from arm/disarm owns this cycle; the sweep waits in place.
        if (!stall) begin
          eval = 1'b1;
          if (cur_armed && (cur_remain <= TIMER_W'(1))) begin
            expire  = 1'b1;
            state_d = S_ISSUE;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + FLOWID_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (sched_update_rdy) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + FLOWID_W'(1);
            state_d = S_SWEEP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      pre_q          <= '0;
      tick_pend_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
      for (int i = 0; i < FLOW_CNT; i++) begin
        armed_q[i]  <= 1'b0;
        remain_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      // A wrap on the same cycle the pending tick is consumed re-arms it; no overrun.
      if (pre_wrap) begin
        tick_pend_q <= 1'b1;
      end else if (tick_clr) begin
        tick_pend_q <= 1'b0;
      end
      if (pre_wrap && tick_pend_q && !tick_clr) begin
        tick_overrun_q <= 1'b1;
      end
      for (int i = 0; i < FLOW_CNT; i++) begin
        if (arm_hit && (arm_flowid == FLOWID_W'(i))) begin
          armed_q[i]  <= 1'b1;
          remain_q[i] <= arm_to_eff;
        end else if (dis_hit && (disarm_flowid == FLOWID_W'(i))) begin
          armed_q[i] <= 1'b0;
        end else if (eval && (idx_q == FLOWID_W'(i))) begin
          if (expire) begin
            armed_q[i]  <= 1'b0;
            remain_q[i] <= '0;
          end else if (cur_armed) begin
            remain_q[i] <= cur_remain - TIMER_W'(1);
          end
        end
      end
    end
  end

  assign arm_rdy          = 1'b1;
  assign disarm_rdy       = ~arm_val;
  assign sched_update_val = (state_q == S_ISSUE);
  // idx holds throughout ISSUE, so it doubles as the latched expired flow id.
  assign sched_update_cmd = {idx_q, SC_SET, SC_NOP, SC_NOP};
  assign tick_overrun     = tick_overrun_q;
  assign dbg_state        = state_q;
  assign dbg_idx          = idx_q;

endmodule
